// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the execute stage: ALU command codes, barrel-shift
// type codes, NZCV bit positions, the multiplier FSM state type and the
// helper that turns MUL_STEP into the multiplier cycle count.
// Optional feature macro used by this slice: FWD_EN (operand forwarding).
// ---------------------------------------------------------------------------
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001,
        CMD_MUL = 4'b1111
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Cycles spent in BUSY for a 32-bit multiplier retiring `step` bits/cycle.
    function automatic int mul_cyc(input int step);
        return 32 / step;
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ---------------------------------------------------------------------------
// exe_stage_if
// Bundles the ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
//   slave  : the execute stage (consumes *_i, drives *_o)
//   master : the surrounding pipeline / bench (drives *_i, consumes *_o)
// With FWD_EN defined the forwarding selects and forwarded values are added.
// ---------------------------------------------------------------------------
interface exe_stage_if;

    logic        wb_en_i;
    logic        mem_r_en_i;
    logic        mem_w_en_i;
    logic        b_i;
    logic        s_i;
    logic        imm_i;
    logic        c_i;
    logic [3:0]  exe_cmd_i;
    logic [31:0] pc_i;
    logic [31:0] val_rn_i;
    logic [31:0] val_rm_i;
    logic [11:0] shift_operand_i;
    logic [23:0] signed_imm_24_i;
    logic [3:0]  dest_i;
`ifdef FWD_EN
    logic [1:0]  sel_src1_i;
    logic [1:0]  sel_src2_i;
    logic [31:0] mem_fwd_i;
    logic [31:0] wb_fwd_i;
`endif

    logic        wb_en_o;
    logic        mem_r_en_o;
    logic        mem_w_en_o;
    logic [31:0] alu_res_o;
    logic [31:0] val_rm_o;
    logic [3:0]  dest_o;
    logic        br_taken_o;
    logic [31:0] br_addr_o;
    logic [3:0]  status_o;
    logic        stall_o;

    modport slave (
`ifdef FWD_EN
        input  sel_src1_i, sel_src2_i, mem_fwd_i, wb_fwd_i,
`endif
        input  wb_en_i, mem_r_en_i, mem_w_en_i, b_i, s_i, imm_i, c_i,
        input  exe_cmd_i, pc_i, val_rn_i, val_rm_i, shift_operand_i,
        input  signed_imm_24_i, dest_i,
        output wb_en_o, mem_r_en_o, mem_w_en_o, alu_res_o, val_rm_o, dest_o,
        output br_taken_o, br_addr_o, status_o, stall_o
    );

    modport master (
`ifdef FWD_EN
        output sel_src1_i, sel_src2_i, mem_fwd_i, wb_fwd_i,
`endif
        output wb_en_i, mem_r_en_i, mem_w_en_i, b_i, s_i, imm_i, c_i,
        output exe_cmd_i, pc_i, val_rn_i, val_rm_i, shift_operand_i,
        output signed_imm_24_i, dest_i,
        input  wb_en_o, mem_r_en_o, mem_w_en_o, alu_res_o, val_rm_o, dest_o,
        input  br_taken_o, br_addr_o, status_o, stall_o
    );

endinterface

// File: rtl/exe_mul_iter.sv
// ---------------------------------------------------------------------------
// exe_mul_iter
// Iterative shift-add multiplier (low 32 bits of the product) with its
// IDLE/BUSY/DONE sequencer.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   start       MUL command present in the execute slot
//   op_a, op_b  multiplicand / multiplier, sampled in the IDLE accept cycle
//   stall       hold upstream (accept cycle + every BUSY cycle)
//   done        product valid this cycle (DONE state)
//   product     low 32 bits of op_a * op_b
// ---------------------------------------------------------------------------
module exe_mul_iter
    import exe_pkg::*;
#(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        stall,
    output logic        done,
    output logic [31:0] product
);

    localparam int         CYC      = mul_cyc(MUL_STEP);
    localparam logic [4:0] CNT_INIT = 5'(CYC - 1);

    mul_state_e  state;
    logic [4:0]  cnt;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] acc_next;

    // Retire MUL_STEP multiplier bits: add the suitably shifted multiplicand
    // for every set bit in the low MUL_STEP positions.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= CNT_INIT;
                        state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    if (cnt == 5'd0) begin
                        state <= MUL_DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    // The accept cycle must stall in the same cycle the MUL appears, so this
    // term is decoded from the state register plus start; rst gates it so
    // that an asserted reset drops stall immediately.
    assign stall   = rst && (((state == MUL_IDLE) && start) || (state == MUL_BUSY));
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage ARM pipeline: Val2 generation, ALU, branch
// target adder, NZCV status register and an iterative multiplier that stalls
// the upstream stages while it runs.
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-low reset
//   bus   exe_stage_if.slave: ID/EX inputs (*_i) and EX/MEM outputs (*_o)
// Parameter MUL_STEP: multiplier bits per cycle (1,2,4,8).
// Optional macro FWD_EN: adds operand forwarding muxes on Rn and Rm.
// ---------------------------------------------------------------------------
module exe_stage
    import exe_pkg::*;
#(
    parameter int MUL_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);

    logic signed [31:0] op_rn;
    logic signed [31:0] op_rm;
    logic signed [31:0] val2;
    logic signed [31:0] br_off;
    logic        [31:0] alu_res;
    logic        [32:0] sum;
    logic               carry_in;
    logic               c_nxt;
    logic               v_nxt;
    logic        [3:0]  status;
    logic        [3:0]  nzcv_nxt;
    logic               stall;
    logic               mul_done;
    logic        [31:0] mul_prod;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] gen_val2(input logic imm, input logic mem,
                                             input logic [11:0] si,
                                             input logic [31:0] rm);
        logic [31:0] r;
        if (imm) begin
            r = ror32({24'b0, si[7:0]}, {si[11:8], 1'b0});
        end else if (mem) begin
            r = {20'b0, si};
        end else begin
            // si[4] would select a register-specified shift; not supported,
            // the amount always comes from si[11:7].
            case (si[6:5])
                SH_LSL:  r = rm << si[11:7];
                SH_LSR:  r = rm >> si[11:7];
                SH_ASR:  r = $signed(rm) >>> si[11:7];
                default: r = ror32(rm, si[11:7]);
            endcase
        end
        return r;
    endfunction

`ifdef FWD_EN
    function automatic logic [31:0] fwd_sel(input logic [1:0] sel, input logic [31:0] idex,
                                            input logic [31:0] mem, input logic [31:0] wb);
        case (sel)
            2'd1:    return mem;
            2'd2:    return wb;
            default: return idex;
        endcase
    endfunction

    assign op_rn = fwd_sel(bus.sel_src1_i, bus.val_rn_i, bus.mem_fwd_i, bus.wb_fwd_i);
    assign op_rm = fwd_sel(bus.sel_src2_i, bus.val_rm_i, bus.mem_fwd_i, bus.wb_fwd_i);
`else
    assign op_rn = bus.val_rn_i;
    assign op_rm = bus.val_rm_i;
`endif

    assign val2 = gen_val2(bus.imm_i, bus.mem_r_en_i | bus.mem_w_en_i,
                           bus.shift_operand_i, op_rm);

    exe_mul_iter #(
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (bus.exe_cmd_i == CMD_MUL),
        .op_a    (op_rn),
        .op_b    (op_rm),
        .stall   (stall),
        .done    (mul_done),
        .product (mul_prod)
    );

    // ALU: add/sub share one 33-bit adder; subtraction is Rn + ~Val2 + cin,
    // so bit 32 is directly the ARM "NOT borrow" carry.
    always_comb begin
        sum      = '0;
        alu_res  = '0;
        carry_in = 1'b0;
        c_nxt    = status[C_BIT];
        v_nxt    = status[V_BIT];
        case (bus.exe_cmd_i)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = op_rn & val2;
            CMD_ORR: alu_res = op_rn | val2;
            CMD_EOR: alu_res = op_rn ^ val2;
            CMD_MUL: alu_res = mul_done ? mul_prod : 32'd0;
            CMD_ADD, CMD_ADC: begin
                carry_in = (bus.exe_cmd_i == CMD_ADC) && bus.c_i;
                sum      = {1'b0, op_rn} + {1'b0, val2} + {32'b0, carry_in};
                alu_res  = sum[31:0];
                c_nxt    = sum[32];
                v_nxt    = (op_rn[31] == val2[31]) && (alu_res[31] != op_rn[31]);
            end
            CMD_SUB, CMD_SBC: begin
                carry_in = (bus.exe_cmd_i == CMD_SUB) || bus.c_i;
                sum      = {1'b0, op_rn} + {1'b0, ~val2} + {32'b0, carry_in};
                alu_res  = sum[31:0];
                c_nxt    = sum[32];
                v_nxt    = (op_rn[31] != val2[31]) && (alu_res[31] != op_rn[31]);
            end
            default: alu_res = '0;
        endcase
    end

    assign nzcv_nxt = {alu_res[31], (alu_res == 32'd0), c_nxt, v_nxt};

    // Status register boundary: flags commit only for S-instructions that
    // are not being held by the multiplier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status <= '0;
        end else if (bus.s_i && !stall) begin
            status <= nzcv_nxt;
        end
    end

    assign br_off = {{6{bus.signed_imm_24_i[23]}}, bus.signed_imm_24_i, 2'b00};

    assign bus.wb_en_o    = bus.wb_en_i    & ~stall;
    assign bus.mem_r_en_o = bus.mem_r_en_i & ~stall;
    assign bus.mem_w_en_o = bus.mem_w_en_i & ~stall;
    assign bus.alu_res_o  = alu_res;
    assign bus.val_rm_o   = op_rm;
    assign bus.dest_o     = bus.dest_i;
    assign bus.br_taken_o = bus.b_i;
    assign bus.br_addr_o  = bus.pc_i + br_off;
    assign bus.status_o   = status;
    assign bus.stall_o    = stall;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
    import exe_pkg::*;

    localparam int     MUL_STEP = 1;
    localparam int     MUL_CYC  = 32 / MUL_STEP;
    localparam longint TWO32    = 64'sd4294967296;
    localparam longint SMAX     = 64'sd2147483647;
    localparam longint SMIN     = -64'sd2147483648;

    logic       clk = 1'b0;
    logic       rst;
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] st;

    logic [3:0] good_cmds [9] = '{CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
                                  CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR};
    logic [3:0] bad_cmds  [6] = '{4'd0, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};

    exe_stage_if bus();

    exe_stage #(.MUL_STEP(MUL_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                           input logic [11:0] si, input logic [31:0] rm);
        longint amt, p, s, r;
        if (imm) return m_rotr({24'h0, si[7:0]}, 2 * int'(si[11:8]));
        if (mem) return {20'h0, si};
        amt = longint'(si[11:7]);
        p   = longint'(1) << amt;
        case (si[6:5])
            2'd0: return 32'(longint'(rm) * p);
            2'd1: return 32'(longint'(rm) / p);
            2'd2: begin
                s = $signed(rm);
                if (s >= 0) r = s / p;
                else        r = -((-s + p - 1) / p);
                return 32'(r);
            end
            default: return m_rotr(rm, int'(amt));
        endcase
    endfunction

    function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                  input logic [31:0] v2, input logic c,
                                  input logic [3:0] st_in,
                                  output logic [31:0] res, output logic [3:0] nzcv);
        longint ur, uv, sr, sv, u, s, k;
        logic cf, vf;
        ur = longint'(rn); uv = longint'(v2);
        sr = $signed(rn);  sv = $signed(v2);
        cf = st_in[1]; vf = st_in[0];
        case (cmd)
            CMD_ADD, CMD_ADC: begin
                k  = (cmd == CMD_ADC && c) ? 1 : 0;
                u  = ur + uv + k; s = sr + sv + k;
                res = 32'(u); cf = (u >= TWO32); vf = (s > SMAX) || (s < SMIN);
            end
            CMD_SUB, CMD_SBC: begin
                k  = (cmd == CMD_SBC && !c) ? 1 : 0;
                u  = ur - uv - k; s = sr - sv - k;
                res = 32'(u); cf = (u >= 0); vf = (s > SMAX) || (s < SMIN);
            end
            CMD_MOV: res = v2;
            CMD_MVN: res = ~v2;
            CMD_AND: res = rn & v2;
            CMD_ORR: res = rn | v2;
            CMD_EOR: res = rn ^ v2;
            default: res = 32'h0;
        endcase
        nzcv = {res[31], res == 32'h0, cf, vf};
    endfunction

    function automatic logic [31:0] m_br(input logic [31:0] pc, input logic [23:0] i24);
        longint off;
        off = longint'(i24);
        if (i24[23]) off = off - (longint'(1) << 24);
        return 32'(longint'(pc) + off * 4);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic [11:0] si, input logic imm, input logic s, input logic c,
                          input logic wb, input logic mr, input logic mw, input logic b,
                          input logic [31:0] pc, input logic [23:0] i24, input logic [3:0] dest);
        bus.exe_cmd_i = cmd;  bus.val_rn_i = rn;   bus.val_rm_i = rm;
        bus.shift_operand_i = si; bus.imm_i = imm; bus.s_i = s;  bus.c_i = c;
        bus.wb_en_i = wb;     bus.mem_r_en_i = mr; bus.mem_w_en_i = mw;
        bus.b_i = b;          bus.pc_i = pc;       bus.signed_imm_24_i = i24;
        bus.dest_i = dest;
    endtask

    // Called one time unit after a rising edge with inputs already applied;
    // returns one time unit after the following rising edge.
    task automatic run_alu(input string tag, input logic directed,
                           input logic [31:0] exp_res, input logic [3:0] exp_st);
        logic [31:0] v2, res;
        logic [3:0]  nz;
        v2 = m_val2(bus.imm_i, bus.mem_r_en_i | bus.mem_w_en_i, bus.shift_operand_i, bus.val_rm_i);
        m_alu(bus.exe_cmd_i, bus.val_rn_i, v2, bus.c_i, st, res, nz);
        #1;
        chk({tag, "_res"},   bus.alu_res_o, res);
        chk({tag, "_stall"}, 32'(bus.stall_o), 32'(1'b0));
        chk({tag, "_wb"},    32'(bus.wb_en_o), 32'(bus.wb_en_i));
        chk({tag, "_mr"},    32'(bus.mem_r_en_o), 32'(bus.mem_r_en_i));
        chk({tag, "_mw"},    32'(bus.mem_w_en_o), 32'(bus.mem_w_en_i));
        chk({tag, "_dest"},  32'(bus.dest_o), 32'(bus.dest_i));
        chk({tag, "_rm"},    bus.val_rm_o, bus.val_rm_i);
        chk({tag, "_bt"},    32'(bus.br_taken_o), 32'(bus.b_i));
        chk({tag, "_ba"},    bus.br_addr_o, m_br(bus.pc_i, bus.signed_imm_24_i));
        if (directed) chk({tag, "_res_k"}, bus.alu_res_o, exp_res);
        @(posedge clk); #1;
        if (bus.s_i) st = nz;
        chk({tag, "_status"}, 32'(bus.status_o), 32'(st));
        if (directed) chk({tag, "_status_k"}, 32'(bus.status_o), 32'(exp_st));
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s);
        int          stalls, wbs;
        logic        done;
        logic [63:0] full;
        logic [31:0] prod;
        full = 64'(a) * 64'(b);
        prod = full[31:0];
        set_in(CMD_MUL, a, b, 12'h0, 1'b0, s, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 4'd3);
        stalls = 0; wbs = 0; done = 1'b0;
        for (int k = 0; k < 4 * MUL_CYC + 8 && !done; k++) begin
            #1;
            if (bus.stall_o === 1'b1) begin
                stalls++;
                if (bus.wb_en_o !== 1'b0) wbs++;
                if (stalls == MUL_CYC) chk({tag, "_st_hold"}, 32'(bus.status_o), 32'(st));
            end else begin
                done = 1'b1;
                chk({tag, "_res"}, bus.alu_res_o, prod);
                if (bus.wb_en_o === 1'b1) wbs++;
            end
            @(posedge clk); #1;
        end
        bus.exe_cmd_i = CMD_NOP; bus.wb_en_i = 1'b0; bus.s_i = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'(1'b1));
        chk({tag, "_stalls"}, 32'(stalls), 32'(MUL_CYC + 1));
        chk({tag, "_wb_once"}, 32'(wbs), 32'd1);
        if (s && done) st = {prod[31], prod == 32'h0, st[1:0]};
        chk({tag, "_status"}, 32'(bus.status_o), 32'(st));
    endtask

    initial begin
        rst = 1'b0;
        set_in(CMD_MUL, 32'd9, 32'd9, 12'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               32'h0, 24'h0, 4'd0);
`ifdef FWD_EN
        bus.sel_src1_i = 2'd0; bus.sel_src2_i = 2'd0;
        bus.mem_fwd_i = 32'h0; bus.wb_fwd_i = 32'h0;
`endif
        st = 4'h0;
        #2;
        chk("rst_stall",  32'(bus.stall_o), 32'(1'b0));
        chk("rst_status", 32'(bus.status_o), 32'h0);
        @(posedge clk); #1;
        chk("rst_status_edge", 32'(bus.status_o), 32'h0);
        bus.exe_cmd_i = CMD_NOP; bus.wb_en_i = 1'b0; bus.s_i = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic / shifter / branch cases
        set_in(CMD_ADD, 32'h7FFF_FFFF, 32'h0, 12'h001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 32'h0, 24'h0, 4'd1);
        run_alu("add_ovf", 1'b1, 32'h8000_0000, 4'b1001);
        set_in(CMD_SUB, 32'd5, 32'h0, 12'h005, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 32'h0, 24'h0, 4'd2);
        run_alu("sub_zero", 1'b1, 32'h0, 4'b0110);
        set_in(CMD_MOV, 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 32'h0, 24'h0, 4'd3);
        run_alu("mov_ror", 1'b1, 32'hFF00_0000, st);
        set_in(CMD_MOV, 32'h0, 32'h8000_0000, 12'h0C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               1'b0, 32'h0, 24'h0, 4'd4);
        run_alu("mov_asr", 1'b1, 32'hC000_0000, st);
        set_in(CMD_NOP, 32'h0, 32'h0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 32'h100, 24'hFFFFFE, 4'd0);
        #1;
        chk("br_taken", 32'(bus.br_taken_o), 32'd1);
        chk("br_addr",  bus.br_addr_o, 32'h0000_00F8);
        @(posedge clk); #1;

        // Randomized ALU traffic against the model
        for (int k = 0; k < 150; k++) begin
            logic [3:0] cmd;
            logic       s;
            cmd = good_cmds[$urandom_range(0, 8)];
            s   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                cmd = bad_cmds[$urandom_range(0, 5)];
                s   = 1'b0;
            end
            set_in(cmd, pick(), pick(), 12'($urandom), 1'($urandom), s, 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                   24'($urandom), 4'($urandom));
            run_alu("rand", 1'b0, 32'h0, 4'h0);
        end

        // Multiplier
        run_mul("mul_7x6", 32'd7, 32'd6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run_mul("mul_rand", pick(), pick(), 1'($urandom));
        end

        // Reset in the middle of BUSY
        set_in(CMD_MUL, 32'd11, 32'd13, 12'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               32'h0, 24'h0, 4'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_stall", 32'(bus.stall_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(bus.stall_o), 32'(1'b0));
        chk("abort_status", 32'(bus.status_o), 32'h0);
        st = 4'h0;
        set_in(CMD_ADD, 32'd1, 32'd1, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h0, 24'h0, 4'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_stall", 32'(bus.stall_o), 32'(1'b0));
        run_mul("mul_after_rst", 32'd3, 32'd5, 1'b1);

`ifdef FWD_EN
        set_in(CMD_ADD, 32'd100, 32'd200, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               32'h0, 24'h0, 4'd0);
        bus.sel_src1_i = 2'd1; bus.sel_src2_i = 2'd2;
        bus.mem_fwd_i = 32'd10; bus.wb_fwd_i = 32'd3;
        #1;
        chk("fwd_res", bus.alu_res_o, 32'd13);
        chk("fwd_rm",  bus.val_rm_o, 32'd3);
        bus.sel_src1_i = 2'd3; bus.sel_src2_i = 2'd3;
        #1;
        chk("fwd_sel3", bus.alu_res_o, 32'd300);
        bus.sel_src1_i = 2'd0; bus.sel_src2_i = 2'd0;
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
